// File: rtl/sb_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : sb_cfg_loader
// Brief    : Serial sync-hunting loader that atomically commits 18 routing
//            words to one 5x4 switch box.
// Revision : 1.0
// ============================================================================
module sb_cfg_loader #(
    parameter int          NUM_TB = 5,
    parameter int          NUM_LR = 4,
    parameter int          WORD_W = 6,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cfg_din,
    input  logic                                    cfg_valid,
    output logic [(2*NUM_TB+2*NUM_LR)*WORD_W-1:0]   cfg_out,
    output logic                                    cfg_busy,
    output logic                                    cfg_done,
    output logic                                    cfg_err,
    output logic [1:0]                              err_cause
);

    localparam int NUM_WORDS = 2*NUM_TB + 2*NUM_LR;
    localparam int OUT_W     = NUM_WORDS*WORD_W;
    localparam int WCNT_W    = $clog2(NUM_WORDS);
    localparam int IDX_W     = WORD_W - 3;
    localparam logic [IDX_W-1:0] TB_LIM = IDX_W'(NUM_TB);
    localparam logic [IDX_W-1:0] LR_LIM = IDX_W'(NUM_LR);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         sr_q, sr_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]  acc_q, acc_d;
    logic               illegal_q, illegal_d;
    logic               cks_bad_q, cks_bad_d;
    logic [OUT_W-1:0]   shadow_q, shadow_d;
    logic [OUT_W-1:0]   cfg_out_q, cfg_out_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         cause_q, cause_d;

    logic [7:0]         sr_shift;
    logic [WORD_W-1:0]  word_in;
    logic               last_bit;

    // Side 0 is "unrouted" and ignores the index; sides 1/3 are top/bottom,
    // sides 2/4 are left/right.
    function automatic logic word_illegal(input logic [WORD_W-1:0] w);
        logic [2:0]       side;
        logic [IDX_W-1:0] idx;
        side = w[2:0];
        idx  = w[WORD_W-1:3];
        case (side)
            3'd0:       word_illegal = 1'b0;
            3'd1, 3'd3: word_illegal = (idx >= TB_LIM);
            3'd2, 3'd4: word_illegal = (idx >= LR_LIM);
            default:    word_illegal = 1'b1;
        endcase
    endfunction

    assign sr_shift = {sr_q[6:0], cfg_din};
    assign word_in  = {sr_q[WORD_W-2:0], cfg_din};
    assign last_bit = (bit_cnt_q == 3'(WORD_W-1));

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        acc_d      = acc_q;
        illegal_d  = illegal_q;
        cks_bad_d  = cks_bad_q;
        shadow_d   = shadow_q;
        cfg_out_d  = cfg_out_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cause_d    = 2'b00;

        case (state_q)
            ST_HUNT: begin
                if (cfg_valid) begin
                    sr_d = sr_shift;
                    if (sr_shift == SYNC) begin
                        state_d    = ST_LOAD;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                    end
                end
            end

            ST_LOAD: begin
                if (cfg_valid) begin
                    sr_d = sr_shift;
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        for (int k = 0; k < NUM_WORDS; k++) begin
                            if (word_cnt_q == WCNT_W'(k))
                                shadow_d[k*WORD_W +: WORD_W] = word_in;
                        end
                        acc_d     = acc_q ^ word_in;
                        illegal_d = illegal_q | word_illegal(word_in);
                        if (word_cnt_q == WCNT_W'(NUM_WORDS-1)) begin
                            word_cnt_d = '0;
                            state_d    = ST_CHECK;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            ST_CHECK: begin
                if (cfg_valid) begin
                    sr_d = sr_shift;
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        cks_bad_d = (word_in != acc_q);
                        state_d   = ST_COMMIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            ST_COMMIT: begin
                // Shadow is only exposed when the whole frame is clean.
                if (!cks_bad_q && !illegal_q) begin
                    cfg_out_d = shadow_q;
                    done_d    = 1'b1;
                end else begin
                    err_d   = 1'b1;
                    cause_d = {illegal_q, cks_bad_q};
                end
                state_d    = ST_HUNT;
                sr_d       = '0;
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                acc_d      = '0;
                illegal_d  = 1'b0;
                cks_bad_d  = 1'b0;
            end

            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            acc_q      <= '0;
            illegal_q  <= 1'b0;
            cks_bad_q  <= 1'b0;
            cfg_out_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cause_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            acc_q      <= acc_d;
            illegal_q  <= illegal_d;
            cks_bad_q  <= cks_bad_d;
            cfg_out_q  <= cfg_out_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cause_q    <= cause_d;
        end
    end

    // Every word is rewritten before any commit, so no reset is needed here.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign cfg_out   = cfg_out_q;
    assign cfg_busy  = (state_q != ST_HUNT);
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign err_cause = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_sb_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_cfg_loader
// Brief    : Scoreboard bench for sb_cfg_loader using directed frames.
// Revision : 1.0
// ============================================================================
module tb_sb_cfg_loader;

    localparam int OUT_W = 108;

    logic             clk;
    logic             rst;
    logic             cfg_din;
    logic             cfg_valid;
    logic [OUT_W-1:0] cfg_out;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_err;
    logic [1:0]       err_cause;

    sb_cfg_loader dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_din   (cfg_din),
        .cfg_valid (cfg_valid),
        .cfg_out   (cfg_out),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .err_cause (err_cause)
    );

    typedef struct packed {
        logic             done;
        logic             err;
        logic [1:0]       cause;
        logic [OUT_W-1:0] out;
        logic [31:0]      cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cyc   = 0;
    int          busy_bad;
    bit          chk_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [OUT_W-1:0] act,
                         input logic [OUT_W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every outcome pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst && (cfg_done || cfg_err)) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b, expected none",
                         cfg_done, cfg_err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_done", OUT_W'(cfg_done), OUT_W'(e.done));
                check("pulse_err", OUT_W'(cfg_err), OUT_W'(e.err));
                check("err_cause", OUT_W'(err_cause), OUT_W'(e.cause));
                check("cfg_out", cfg_out, e.out);
                check("latency_cycle", OUT_W'(cyc), OUT_W'(e.cyc));
            end
        end
    end

    task automatic send_bit(input logic b, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                if (chk_busy && !cfg_busy) busy_bad++;
                cfg_valid = 1'b0;
                cfg_din   = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        if (chk_busy && !cfg_busy) busy_bad++;
        cfg_valid = 1'b1;
        cfg_din   = b;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gaps);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
    endtask

    // Sends sync plus n_words words; a full frame also sends the checksum
    // and posts the expected outcome two edges after the last sampled bit.
    task automatic send_frame(input logic [OUT_W-1:0] fr, input logic [5:0] cks,
                              input bit gaps, input int n_words,
                              input logic e_done, input logic [1:0] e_cause,
                              input logic [OUT_W-1:0] e_out);
        exp_t e;
        send_byte(8'hA5, gaps);
        busy_bad = 0;
        chk_busy = 1'b1;
        for (int k = 0; k < n_words; k++)
            for (int i = 5; i >= 0; i--) send_bit(fr[k*6 + i], gaps);
        if (n_words == 18) begin
            for (int i = 5; i >= 0; i--) send_bit(cks[i], gaps);
            e.done  = e_done;
            e.err   = ~e_done;
            e.cause = e_cause;
            e.out   = e_out;
            e.cyc   = cyc + 2;
            sb_q.push_back(e);
        end
        @(negedge clk);
        chk_busy  = 1'b0;
        cfg_valid = 1'b0;
        check("busy_during_frame", OUT_W'(busy_bad), '0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL outcome_timeout: %0d pending, expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    logic [OUT_W-1:0] f1, f1b, f3, f4;

    initial begin
        f1  = '0; f1[5:0]    = 6'o11; f1[107:102] = 6'o04;
        f1b = '0; f1b[5:0]   = 6'b111000; f1b[35:30] = 6'b000011;
        f1b[83:78] = 6'b011010;
        f3  = '0; f3[65:60]  = 6'b100010;
        f4  = '0; f4[17:12]  = 6'b000111;
        chk_busy  = 1'b0;
        busy_bad  = 0;
        cfg_din   = 1'b0;
        cfg_valid = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        check("reset_cfg_out", cfg_out, '0);
        check("reset_busy", OUT_W'(cfg_busy), '0);
        check("reset_done", OUT_W'(cfg_done), '0);
        check("reset_err", OUT_W'(cfg_err), '0);
        check("reset_cause", OUT_W'(err_cause), '0);

        send_byte(8'h33, 1'b0);
        send_frame(f1, 6'o15, 1'b0, 18, 1'b1, 2'b00, f1);
        drain();
        send_frame(f1, 6'o00, 1'b0, 18, 1'b0, 2'b01, f1);
        drain();
        send_frame(f3, 6'b100010, 1'b0, 18, 1'b0, 2'b10, f1);
        drain();
        send_frame(f4, 6'b000000, 1'b0, 18, 1'b0, 2'b11, f1);
        drain();
        send_frame(f1b, 6'b100001, 1'b0, 18, 1'b1, 2'b00, f1b);
        drain();
        send_frame(f1, 6'o15, 1'b1, 18, 1'b1, 2'b00, f1);
        drain();
        send_frame(f1b, 6'b100001, 1'b0, 18, 1'b1, 2'b00, f1b);
        drain();

        // Abort mid-frame after word 9 with an asynchronous reset.
        send_frame(f1, 6'o15, 1'b0, 9, 1'b0, 2'b00, '0);
        #2 rst = 1'b1;
        #1;
        check("async_reset_cfg_out", cfg_out, '0);
        check("async_reset_busy", OUT_W'(cfg_busy), '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(f1, 6'o15, 1'b0, 18, 1'b1, 2'b00, f1);
        drain();
        check("final_cfg_out", cfg_out, f1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sb_cfg_loader.md
Name: sb_cfg_loader

Overview:
- Serial configuration loader for one 5x4 switch box; writes the config words the switch box reads.
- Hunts for a sync header in a 1-bit configuration stream, then collects 18 six-bit routing words and a 6-bit checksum.
- Validates every word and commits all 18 atomically to a flattened config bus that drives the switch box select registers.
- Sits between the device configuration shifter and each switch box instance.

Parameters:
- NUM_TB, 5, lines on top and on bottom.
- NUM_LR, 4, lines on left and on right.
- WORD_W, 6, config word width: [2:0] side code, [5:3] line index.
- SYNC, 8'hA5, frame sync header, MSB first.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_din  in  1  serial config bit.
- cfg_valid  in  1  cfg_din is sampled only on cycles where this is 1.
- cfg_out  out  108  committed words; word k at [6k+5:6k]. Order: top0-4 (k=0-4), bottom0-4 (k=5-9), left0-3 (k=10-13), right0-3 (k=14-17).
- cfg_busy  out  1  high from the cycle after sync is matched until the commit/reject cycle.
- cfg_done  out  1  one-cycle pulse on successful commit.
- cfg_err  out  1  one-cycle pulse on frame rejection.
- err_cause  out  2  valid while cfg_err is high: 01 checksum mismatch, 10 illegal word, 11 both; otherwise 00.

Behaviour:
- Reset values (asynchronous): cfg_out=0 (all outputs high-Z/unrouted), cfg_busy=0, cfg_done=0, cfg_err=0, err_cause=0. State goes to HUNT; shift register, counters, checksum accumulator and illegal flag are cleared.
- A bit is consumed only when cfg_valid=1; idle cycles stall every state. Words and checksum are MSB first.
- HUNT:
  - 8-bit shift register; each valid bit shifts in at the LSB.
  - When the value after the shift equals SYNC, go to LOAD on the next edge.
  - Sliding match: overlapping or garbage prefixes are tolerated.
- LOAD:
  - Bit counter 0..5 and word counter 0..17.
  - On the 6th bit, the word is written to shadow[k]. acc ^= word. Illegal flag is set if:
    - side code 5, 6 or 7; or
    - side code 1 or 3 with index >= NUM_TB; or
    - side code 2 or 4 with index >= NUM_LR.
  - Side code 0 is legal with any index.
  - After word 17 completes, go to CHECK.
- CHECK:
  - Collect 6 bits.
  - On the 6th bit, compare with acc, then go to COMMIT.
- COMMIT: exactly one cycle, consumes no bits.
  - If there is no error: cfg_out <= shadow (all 18 words in the same edge), cfg_done=1.
  - Otherwise: cfg_out is held unchanged, cfg_err=1, err_cause is set.
  - Next state is HUNT with counters, acc and flag cleared.
- Latency: cfg_done/cfg_err and the new cfg_out appear 2 clock edges after the edge that samples the last checksum bit (one edge to enter COMMIT, one edge to register outputs).
- cfg_out changes only on a successful commit; partial frames are never visible.
- Sync patterns inside LOAD/CHECK are data, not resynchronisation.
- Reset mid-frame: shadow contents are discarded and cfg_out returns to 0.
- A new frame may start in the cycle after COMMIT. Bits presented during the COMMIT cycle are ignored.
- Shadow registers need no reset; they are fully overwritten before any commit.

Test Plan:
- Reset, then idle -> cfg_out=0, cfg_busy=0, no pulses.
- Send 0x33 garbage, then A5; top0=6'o11 (side 1, idx 1), right3=6'o04 (side 4, idx 0), all other words 0; checksum 6'o15 -> one cfg_done pulse; cfg_out[5:0]=6'b001001, cfg_out[107:102]=6'b000100, all other bits 0.
- Same frame with checksum 6'o00 -> cfg_err=1, err_cause=01, cfg_out keeps its previous value.
- Frame with left0=6'b100010 (side 2, idx 4 >= NUM_LR) and a correct checksum -> err_cause=10. Second frame with top2=6'b000111 (side 7) and a wrong checksum -> err_cause=11.
- Valid frame with cfg_valid toggling randomly 50% -> result identical to the contiguous case; cfg_busy stays high throughout.
- Assert rst at word 9 of a frame after a prior commit -> cfg_out=0 immediately (async). The next full valid frame commits normally.
